// File: rtl/bounce_generator.sv
// Switch-bounce emulator: turns a clean target level into a glitching, registered output.
// Optional build macro BOUNCE_GEN_RANDOM_EN swaps the alternating glitch pattern for LFSR noise.
module bounce_generator #(
    parameter int          BOUNCE_TICKS = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic target_in,
    output logic bouncy_out,
    output logic busy
);

    localparam int              CW   = $clog2(BOUNCE_TICKS) + 1;
    localparam logic [CW-1:0]   LAST = CW'(BOUNCE_TICKS - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_0        = 2'b00,
        S_BOUNCE_1 = 2'b01,
        S_1        = 2'b10,
        S_BOUNCE_0 = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] counter, counter_nxt;
    logic          out_nxt, busy_nxt;
    logic          bounce_level;
    logic          pattern_bit;

    assign bounce_level = (state == S_BOUNCE_1);

`ifdef BOUNCE_GEN_RANDOM_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Free-running so the glitch sequence is a pure function of cycles since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign pattern_bit = lfsr[0];
`else
    // Next k is counter+1: odd when counter is even, and odd k shows the old level.
    assign pattern_bit = counter[0] ? bounce_level : ~bounce_level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_0;
            counter    <= '0;
            bouncy_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            counter    <= counter_nxt;
            bouncy_out <= out_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        out_nxt     = bouncy_out;
        busy_nxt    = busy;
        case (state)
            S_0: begin
                out_nxt  = 1'b0;
                busy_nxt = 1'b0;
                if (target_in) begin
                    state_nxt   = S_BOUNCE_1;
                    counter_nxt = '0;
                    out_nxt     = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            S_1: begin
                out_nxt  = 1'b1;
                busy_nxt = 1'b0;
                if (!target_in) begin
                    state_nxt   = S_BOUNCE_0;
                    counter_nxt = '0;
                    out_nxt     = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            S_BOUNCE_1, S_BOUNCE_0: begin
                // target_in is deliberately ignored until the window has run its full length.
                if (counter == LAST) begin
                    state_nxt = bounce_level ? S_1 : S_0;
                    out_nxt   = bounce_level;
                    busy_nxt  = 1'b0;
                end else begin
                    counter_nxt = counter + ONE;
                    out_nxt     = pattern_bit;
                    busy_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt   = S_0;
                counter_nxt = '0;
                out_nxt     = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench for bounce_generator against an edge-counting reference model.
module tb_bounce_generator;

`ifdef BOUNCE_GEN_RANDOM_EN
    localparam int TICKS = 8;
`else
    localparam int TICKS = 4;
`endif
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic target_in = 1'b0;
    logic bouncy_out;
    logic busy;

    int checks = 0;
    int failures = 0;

    // Reference model: window timing derived from the edge index at which it opened.
    logic        m_level = 1'b0;
    logic        m_in_win = 1'b0;
    logic        exp_out = 1'b0;
    logic        exp_busy = 1'b0;
    int          m_edge = 0;
    int          m_start = 0;
    logic [15:0] m_lfsr = SEED;

    bounce_generator #(
        .BOUNCE_TICKS(TICKS),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .target_in(target_in),
        .bouncy_out(bouncy_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic pattern(input int j, input logic lvl, input logic [15:0] s);
`ifdef BOUNCE_GEN_RANDOM_EN
        return (j == 0) ? lvl : s[0];
`else
        return (j % 2 == 0) ? lvl : ~lvl;
`endif
    endfunction

    task automatic model_step(input logic r, input logic t);
        logic [15:0] sampled;
        int j;
        if (r) begin
            m_level  = 1'b0;
            m_in_win = 1'b0;
            m_edge   = 0;
            m_lfsr   = SEED;
            exp_out  = 1'b0;
            exp_busy = 1'b0;
        end else begin
            sampled = m_lfsr;
            m_lfsr  = lfsr_next(m_lfsr);
            m_edge++;
            if (m_in_win) begin
                j = m_edge - m_start;
                if (j >= TICKS) begin
                    m_in_win = 1'b0;
                    exp_out  = m_level;
                    exp_busy = 1'b0;
                end else begin
                    exp_out  = pattern(j, m_level, sampled);
                    exp_busy = 1'b1;
                end
            end else if (t !== m_level) begin
                m_level  = t;
                m_start  = m_edge;
                m_in_win = 1'b1;
                exp_out  = t;
                exp_busy = 1'b1;
            end else begin
                exp_out  = m_level;
                exp_busy = 1'b0;
            end
        end
    endtask

    // Drive inputs, let one rising edge sample them, then settle 1 time unit before checking.
    task automatic cycle(input logic r, input logic t);
        rst = r;
        target_in = t;
        @(posedge clk);
        model_step(r, t);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1);
            checks += 2;
            if (bouncy_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_out cyc %0d: got %b want 0", i, bouncy_out);
            end
            if (busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_busy cyc %0d: got %b want 0", i, busy);
            end
        end
        cycle(1'b0, 1'b1);
        checks += 2;
        if (bouncy_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_window_out: got %b want 1", bouncy_out);
        end
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_window_busy: got %b want 1", busy);
        end
        for (int i = 1; i <= TICKS + 1; i++) begin
            cycle(1'b0, 1'b1);
            checks += 2;
            if (bouncy_out !== exp_out) begin
                failures++;
                $display("[TB] FAIL first_window_out k=%0d: got %b want %b", i, bouncy_out, exp_out);
            end
            if (busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL first_window_busy k=%0d: got %b want %b", i, busy, exp_busy);
            end
        end
    endtask

    task automatic test_window(input logic lvl, input string name);
        int busy_cnt = 0;
        for (int i = 0; i < TICKS + 3; i++) begin
            cycle(1'b0, lvl);
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            checks += 2;
            if (bouncy_out !== exp_out) begin
                failures++;
                $display("[TB] FAIL %s_out cyc %0d: got %b want %b", name, i, bouncy_out, exp_out);
            end
            if (busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL %s_busy cyc %0d: got %b want %b", name, i, busy, exp_busy);
            end
        end
        checks += 2;
        if (busy_cnt != TICKS) begin
            failures++;
            $display("[TB] FAIL %s_busy_len: got %0d want %0d", name, busy_cnt, TICKS);
        end
        if (bouncy_out !== lvl) begin
            failures++;
            $display("[TB] FAIL %s_settle: got %b want %b", name, bouncy_out, lvl);
        end
    endtask

    task automatic test_reversal;
        for (int i = 0; i < 2 * TICKS + 5; i++) begin
            cycle(1'b0, (i < 2) ? 1'b1 : 1'b0);
            checks += 2;
            if (bouncy_out !== exp_out) begin
                failures++;
                $display("[TB] FAIL reversal_out cyc %0d: got %b want %b", i, bouncy_out, exp_out);
            end
            if (busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL reversal_busy cyc %0d: got %b want %b", i, busy, exp_busy);
            end
            if (i == TICKS) begin
                checks++;
                if (bouncy_out !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL reversal_mid_settle: got out=%b busy=%b want 1/0", bouncy_out, busy);
                end
            end
        end
        checks++;
        if (bouncy_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reversal_final: got out=%b busy=%b want 0/0", bouncy_out, busy);
        end
    endtask

    task automatic test_back_to_back;
        for (int rep = 0; rep < 4; rep++) begin
            for (int i = 0; i < TICKS + 1; i++) begin
                cycle(1'b0, (rep % 2 == 0) ? 1'b1 : 1'b0);
                checks += 2;
                if (bouncy_out !== exp_out) begin
                    failures++;
                    $display("[TB] FAIL b2b_out rep %0d cyc %0d: got %b want %b", rep, i, bouncy_out, exp_out);
                end
                if (busy !== exp_busy) begin
                    failures++;
                    $display("[TB] FAIL b2b_busy rep %0d cyc %0d: got %b want %b", rep, i, busy, exp_busy);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1);
            checks += 2;
            if (bouncy_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_mid_out cyc %0d: got %b want 0", i, bouncy_out);
            end
            if (busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_mid_busy cyc %0d: got %b want 0", i, busy);
            end
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (bouncy_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_hold: got out=%b busy=%b want 0/0", bouncy_out, busy);
        end
    endtask

    task automatic test_random;
        logic t = 1'b0;
        logic r;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) t = ~t;
            r = ($urandom_range(0, 59) == 0);
            cycle(r, t);
            checks += 2;
            if (bouncy_out !== exp_out) begin
                failures++;
                $display("[TB] FAIL random_out cyc %0d: got %b want %b", i, bouncy_out, exp_out);
            end
            if (busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL random_busy cyc %0d: got %b want %b", i, busy, exp_busy);
            end
        end
    endtask

    task automatic test_repeat;
        logic stim [40];
        logic first_run [40];
        for (int i = 0; i < 40; i++) stim[i] = ($urandom_range(0, 4) == 0);
        for (int pass = 0; pass < 2; pass++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b1, 1'b0);
            for (int i = 0; i < 40; i++) begin
                if (i > 0 && stim[i]) stim[i] = stim[i];
                cycle(1'b0, (i / (TICKS + 2)) % 2 == 0 ? 1'b1 : stim[i]);
                checks++;
                if (bouncy_out !== exp_out) begin
                    failures++;
                    $display("[TB] FAIL repeat_model pass %0d cyc %0d: got %b want %b", pass, i, bouncy_out, exp_out);
                end
                if (pass == 0) begin
                    first_run[i] = bouncy_out;
                end else begin
                    checks++;
                    if (bouncy_out !== first_run[i]) begin
                        failures++;
                        $display("[TB] FAIL repeat_replay cyc %0d: got %b want %b", i, bouncy_out, first_run[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_window(1'b0, "falling");
        test_window(1'b1, "rising");
        test_window(1'b0, "falling2");
        test_reversal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
